// File: rtl/appx_mult_pkg.sv
// Shared definitions for the approximate-multiplier result path.
// Holds the accumulator FSM states, the signed sum limits and the term-forming helper.
package appx_mult_pkg;

    localparam int PROD_W = 64;
    localparam int TERM_W = PROD_W + 2;

    localparam logic [PROD_W-1:0] SUM_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [PROD_W-1:0] SUM_MIN = 64'h8000_0000_0000_0000;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // The magnitude is widened by two bits first, so negating 2^64-1 cannot wrap.
    function automatic logic [TERM_W-1:0] signed_term(input logic [PROD_W-1:0] mag,
                                                      input logic            neg);
        logic [TERM_W-1:0] ext_v;
        ext_v = {2'b00, mag};
        if (neg) begin
            signed_term = ~ext_v + 66'd1;
        end else begin
            signed_term = ext_v;
        end
    endfunction

endpackage

// File: rtl/appx_mult_accum_sat_add66.sv
// Combinational 66-bit add of a 64-bit signed accumulator and a 66-bit signed term,
// clamped to the 64-bit signed range, with a flag raised whenever the clamp engages.
module sat_add66
    import appx_mult_pkg::*;
(
    input  logic [PROD_W-1:0] acc,
    input  logic [TERM_W-1:0] term,
    output logic [PROD_W-1:0] sum,
    output logic              clamp
);

    logic [TERM_W-1:0] raw_s;
    logic              pos_ovf_s;
    logic              neg_ovf_s;

    // The exact sum always fits in 66 bits; it fits in 64 only when bits 65..63 agree.
    always_comb begin
        raw_s     = {{2{acc[PROD_W-1]}}, acc} + term;
        pos_ovf_s = 1'b0;
        neg_ovf_s = 1'b0;
        if (raw_s[TERM_W-1] == 1'b0) begin
            pos_ovf_s = raw_s[TERM_W-2] | raw_s[TERM_W-3];
        end else begin
            neg_ovf_s = ~(raw_s[TERM_W-2] & raw_s[TERM_W-3]);
        end
    end

    // Select the clamped or the in-range result.
    always_comb begin
        sum   = raw_s[PROD_W-1:0];
        clamp = 1'b0;
        if (pos_ovf_s) begin
            sum   = SUM_MAX;
            clamp = 1'b1;
        end else if (neg_ovf_s) begin
            sum   = SUM_MIN;
            clamp = 1'b1;
        end else begin
            sum   = raw_s[PROD_W-1:0];
            clamp = 1'b0;
        end
    end

endmodule

// File: rtl/appx_mult_accum.sv
// Signed, saturating dot-product accumulator behind the approximate multipliers.
// Beats are sign-restored in S1, summed in S2, and each last-terminated group yields one result.
module appx_mult_accum
    import appx_mult_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [63:0]       in_prod,
    input  logic              in_sign,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_sat
);

    state_e             state_r;
    state_e             state_nxt_s;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               in_ready_nxt_s;
    logic               out_valid_nxt_s;
    logic               accept_s;
    logic               clear_s;

    logic               s1_valid_r;
    logic               s1_last_r;
    logic [TERM_W-1:0]  s1_term_r;

    logic [PROD_W-1:0]  acc_r;
    logic [CNT_W-1:0]   count_r;
    logic               sat_r;
    logic [PROD_W-1:0]  add_sum_s;
    logic               add_clamp_s;

    // in_ready_r tracks "state is ACCUM"; it is masked while reset is held.
    assign in_ready  = in_ready_r & ~rst;
    assign out_valid = out_valid_r;
    assign out_sum   = acc_r;
    assign out_count = count_r;
    assign out_sat   = sat_r;

    assign accept_s  = in_valid & in_ready;
    assign clear_s   = (state_r == HOLD) & out_ready;

    // Next-state logic: DRAIN waits until S1 has emptied into the accumulator.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ACCUM: begin
                if (accept_s && in_last) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            DRAIN: begin
                if (s1_valid_r && s1_last_r) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt_s = ACCUM;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = ACCUM;
            end
        endcase
    end

    // Handshake flags are decoded from the next state so they register alongside it.
    always_comb begin
        in_ready_nxt_s  = 1'b0;
        out_valid_nxt_s = 1'b0;
        if (state_nxt_s == ACCUM) begin
            in_ready_nxt_s = 1'b1;
        end else begin
            in_ready_nxt_s = 1'b0;
        end
        if (state_nxt_s == HOLD) begin
            out_valid_nxt_s = 1'b1;
        end else begin
            out_valid_nxt_s = 1'b0;
        end
    end

    // FSM state and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ACCUM;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
        end
    end

    // S1: capture the accepted beat as a 66-bit signed term.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_term_r  <= 66'd0;
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_last_r <= in_last;
                s1_term_r <= signed_term(in_prod, in_sign);
            end
        end
    end

    sat_add66 u_sat_add66 (
        .acc   (acc_r),
        .term  (s1_term_r),
        .sum   (add_sum_s),
        .clamp (add_clamp_s)
    );

    // S2: saturating accumulate, sticky clamp flag and saturating term count.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r   <= 64'd0;
            count_r <= {CNT_W{1'b0}};
            sat_r   <= 1'b0;
        end else if (clear_s) begin
            acc_r   <= 64'd0;
            count_r <= {CNT_W{1'b0}};
            sat_r   <= 1'b0;
        end else if (s1_valid_r) begin
            acc_r <= add_sum_s;
            sat_r <= sat_r | add_clamp_s;
            if (count_r != {CNT_W{1'b1}}) begin
                count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_appx_mult_accum.sv
// Self-checking bench for appx_mult_accum: a vector table of groups with hand-computed
// results queued on a scoreboard, plus backpressure and mid-group reset sequences.
module tb_appx_mult_accum;

  typedef struct {
    int unsigned        n;
    logic [3:0][63:0]   prod;
    logic [3:0]         sign;
    logic [63:0]        sum;
    logic [15:0]        cnt;
    logic               sat;
  } vec_t;

  typedef struct packed {
    logic [63:0] sum;
    logic [15:0] cnt;
    logic        sat;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_prod;
  logic        in_sign;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_sum;
  logic [15:0] out_count;
  logic        out_sat;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[10];

  appx_mult_accum #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_sign   (in_sign),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input int unsigned n,
                              input logic [63:0] p0, input logic s0,
                              input logic [63:0] p1, input logic s1,
                              input logic [63:0] p2, input logic s2,
                              input logic [63:0] p3, input logic s3,
                              input logic [63:0] sum, input logic [15:0] cnt,
                              input logic sat);
    vec_t v;
    v.n = n;
    v.prod[0] = p0; v.sign[0] = s0;
    v.prod[1] = p1; v.sign[1] = s1;
    v.prod[2] = p2; v.sign[2] = s2;
    v.prod[3] = p3; v.sign[3] = s3;
    v.sum = sum; v.cnt = cnt; v.sat = sat;
    return v;
  endfunction

  function automatic exp_t mk_exp(input logic [63:0] sum, input logic [15:0] cnt, input logic sat);
    exp_t e;
    e.sum = sum; e.cnt = cnt; e.sat = sat;
    return e;
  endfunction

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic drive_beat(input logic [63:0] p, input logic s, input logic l);
    int guard;
    guard = 0;
    in_valid = 1'b1; in_prod = p; in_sign = s; in_last = l;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL beat_timeout: in_ready %b after %0d cycles, required 1", in_ready, guard);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d results pending, required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
    check("ready_after_hs", {63'd0, in_ready}, 64'd1);
    check("valid_after_hs", {63'd0, out_valid}, 64'd0);
  endtask

  // Scoreboard monitor: a result handshake happens at the rising edge after this sample.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_result: sum %h with empty scoreboard, required none", out_sum);
      end else begin
        mon_e = sb.pop_front();
        check("res_sum", out_sum, mon_e.sum);
        check("res_count", {48'd0, out_count}, {48'd0, mon_e.cnt});
        check("res_sat", {63'd0, out_sat}, {63'd0, mon_e.sat});
        check("res_in_ready_low", {63'd0, in_ready}, 64'd0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: bench still running, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    vecs[0] = mk(3, 64'd6, 1'b0, 64'd10, 1'b1, 64'd4, 1'b0, 64'd0, 1'b0,
                 64'd0, 16'd3, 1'b0);
    vecs[1] = mk(1, 64'd3, 1'b1, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0,
                 64'hFFFF_FFFF_FFFF_FFFD, 16'd1, 1'b0);
    vecs[2] = mk(3, 64'h4000_0000_0000_0000, 1'b0, 64'h4000_0000_0000_0000, 1'b0,
                 64'h4000_0000_0000_0000, 1'b0, 64'd0, 1'b0,
                 64'h7FFF_FFFF_FFFF_FFFF, 16'd3, 1'b1);
    vecs[3] = mk(1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0,
                 64'h8000_0000_0000_0000, 16'd1, 1'b1);
    vecs[4] = mk(1, 64'd0, 1'b1, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0,
                 64'd0, 16'd1, 1'b0);
    vecs[5] = mk(2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd10, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0,
                 64'h8000_0000_0000_000A, 16'd2, 1'b1);
    vecs[6] = mk(4, 64'd1000, 1'b0, 64'd3000, 1'b1, 64'd500, 1'b0, 64'd2500, 1'b0,
                 64'd1000, 16'd4, 1'b0);
    vecs[7] = mk(1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0,
                 64'h7FFF_FFFF_FFFF_FFFF, 16'd1, 1'b0);
    vecs[8] = mk(1, 64'h8000_0000_0000_0000, 1'b1, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0,
                 64'h8000_0000_0000_0000, 16'd1, 1'b0);
    vecs[9] = mk(2, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 64'd1, 1'b1, 64'd0, 1'b0, 64'd0, 1'b0,
                 64'h7FFF_FFFF_FFFF_FFFE, 16'd2, 1'b0);

    rst = 1'b1; in_valid = 1'b0; in_prod = 64'd0; in_sign = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("post_rst_sum", out_sum, 64'd0);
    check("post_rst_count", {48'd0, out_count}, 64'd0);
    check("post_rst_sat", {63'd0, out_sat}, 64'd0);
    @(negedge clk);

    // Table: each group, with result latency checked two edges after the last beat.
    for (int v = 0; v < 10; v++) begin
      sb.push_back(mk_exp(vecs[v].sum, vecs[v].cnt, vecs[v].sat));
      for (int b = 0; b < int'(vecs[v].n); b++)
        drive_beat(vecs[v].prod[b], vecs[v].sign[b], (b == int'(vecs[v].n) - 1));
      in_valid = 1'b0; in_last = 1'b0;
      check("lat_t0", {63'd0, out_valid}, 64'd0);
      @(negedge clk);
      check("lat_t1", {63'd0, out_valid}, 64'd0);
      @(negedge clk);
      check("lat_t2", {63'd0, out_valid}, 64'd1);
      wait_drain();
    end

    // Backpressure: result held, pending beat ignored, next group starts from zero.
    out_ready = 1'b0;
    sb.push_back(mk_exp(64'd6, 16'd2, 1'b0));
    drive_beat(64'd5, 1'b0, 1'b0);
    drive_beat(64'd1, 1'b0, 1'b1);
    in_valid = 1'b1; in_prod = 64'd99; in_sign = 1'b0; in_last = 1'b1;
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    for (int k = 0; k < 5; k++) begin
      check("hold_valid_no_ready", {62'd0, out_valid, in_ready}, 64'd2);
      check("hold_sum", out_sum, 64'd6);
      check("hold_count", {48'd0, out_count}, 64'd2);
      @(negedge clk);
    end
    sb.push_back(mk_exp(64'd99, 16'd1, 1'b0));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drive_beat(64'd99, 1'b0, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    wait_drain();

    // Reset after two beats of a group discards it.
    drive_beat(64'd100, 1'b0, 1'b0);
    drive_beat(64'd200, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_mid_no_valid", {63'd0, out_valid}, 64'd0);
    end
    check("rst_mid_count", {48'd0, out_count}, 64'd0);
    check("rst_mid_sum", out_sum, 64'd0);
    sb.push_back(mk_exp(64'd7, 16'd1, 1'b0));
    drive_beat(64'd7, 1'b0, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
